// File: rtl/eqv_sig_engine_if.sv
// Handshake and data bundle between the self-check harness and eqv_sig_engine.
// The harness side (master) drives start/num_pat and the netlist responses.
interface eqv_sig_engine_if #(
  parameter int N_IN  = 14,
  parameter int N_OUT = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_pat;
  logic [N_IN-1:0]  pat_o;
  logic [N_OUT-1:0] gold_i;
  logic [N_OUT-1:0] cand_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [31:0]      gold_sig;
  logic [31:0]      cand_sig;
  logic [CNT_W-1:0] fail_idx;
  logic             fail_vld;

  modport master (
    output start, num_pat, gold_i, cand_i,
    input  pat_o, busy, done, pass, gold_sig, cand_sig, fail_idx, fail_vld
  );

  modport slave (
    input  start, num_pat, gold_i, cand_i,
    output pat_o, busy, done, pass, gold_sig, cand_sig, fail_idx, fail_vld
  );
endinterface

// File: rtl/eqv_sig_engine.sv
// LFSR-driven equivalence checker: compacts golden/candidate responses into MISRs.
// Optional macro EQV_SIG_DIRECT_CMP_EN adds a per-pattern comparator with first-fail index.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last result
// ST_RUN   | one pattern per cycle, plus one closing cycle with no issue
// ST_DRAIN | LAT cycles letting in-flight responses reach the MISRs
// ST_DONE  | done pulse; pass registered on the way in
module eqv_sig_engine #(
  parameter int          N_IN  = 14,
  parameter int          N_OUT = 8,
  parameter int          CNT_W = 16,
  parameter int          LAT   = 1,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst_n,
  eqv_sig_engine_if.slave  bus
);

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY  = 32'h0400_0007;
  localparam logic [2:0]  DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_nxt;
  logic [31:0]      gold_sig;
  logic [31:0]      cand_sig;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] num_pat_q;
  logic [2:0]       drain_cnt;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             issue;
  logic             start_acc;
  logic             tag_vld;
  logic             pass_now;
  logic             fail_vld_q;
  logic [CNT_W-1:0] fail_idx_q;

  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [N_OUT-1:0] resp);
    logic [31:0] ext;
    ext = '0;
    ext[N_OUT-1:0] = resp;
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ ext;
  endfunction

  assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  assign issue     = (state == ST_RUN) && (pat_cnt != num_pat_q);
  assign start_acc = (state == ST_IDLE) && bus.start;
  assign pass_now  = (gold_sig == cand_sig) && !fail_vld_q;

  // Valid tag travels alongside each pattern so only real responses are compacted.
  if (LAT == 0) begin : g_tag_direct
    assign tag_vld = issue;
  end else begin : g_tag_pipe
    logic [LAT-1:0] vld_sr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vld_sr <= '0;
      else if (start_acc) vld_sr <= '0;
      else                vld_sr <= (vld_sr << 1) | LAT'(issue);
    end
    assign tag_vld = vld_sr[LAT-1];
  end

`ifdef EQV_SIG_DIRECT_CMP_EN
  logic [CNT_W-1:0] tag_idx;

  if (LAT == 0) begin : g_idx_direct
    assign tag_idx = pat_cnt;
  end else begin : g_idx_pipe
    logic [CNT_W-1:0] idx_sr [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) idx_sr[i] <= '0;
      end else begin
        idx_sr[0] <= pat_cnt;
        for (int i = 1; i < LAT; i++) idx_sr[i] <= idx_sr[i-1];
      end
    end
    assign tag_idx = idx_sr[LAT-1];
  end

  // First mismatch wins; later ones must not move the reported index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
    end else if (start_acc) begin
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
    end else if (tag_vld && !fail_vld_q && (bus.gold_i != bus.cand_i)) begin
      fail_vld_q <= 1'b1;
      fail_idx_q <= tag_idx;
    end
  end
`else
  assign fail_vld_q = 1'b0;
  assign fail_idx_q = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= SEED;
      gold_sig  <= '0;
      cand_sig  <= '0;
      pat_cnt   <= '0;
      num_pat_q <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tag_vld) begin
        gold_sig <= misr_step(gold_sig, bus.gold_i);
        cand_sig <= misr_step(cand_sig, bus.cand_i);
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            lfsr      <= SEED;
            gold_sig  <= '0;
            cand_sig  <= '0;
            pat_cnt   <= '0;
            num_pat_q <= bus.num_pat;
            if (bus.num_pat == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              pass_q <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              pass_q <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            lfsr    <= lfsr_nxt;
            pat_cnt <= pat_cnt + CNT_W'(1);
          end else if (LAT == 0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= pass_now;
          end else begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= pass_now;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pat_o    = lfsr[N_IN-1:0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.gold_sig = gold_sig;
  assign bus.cand_sig = cand_sig;
  assign bus.fail_idx = fail_idx_q;
  assign bus.fail_vld = fail_vld_q;

endmodule

// File: doc/eqv_sig_engine.md
# eqv_sig_engine

Sequential equivalence-signature engine for optimized gate-level netlists. It drives pseudo-random input vectors into a golden netlist and a candidate netlist in parallel. It compacts both output streams into MISR signatures and reports pass/fail after a programmable pattern count. It sits in the optimization flow's self-check harness, wrapping two combinational or shallow-pipelined netlist instances of identical port shape.

## Interface
- N_IN, 14, netlist input width (1..32)
- N_OUT, 8, netlist output width (1..32)
- CNT_W, 16, pattern-counter width
- LAT, 1, cycles from pat_o change to valid netlist outputs (0..4)
- SEED, 32'hACE1_2024, LFSR load value; must be nonzero
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- num_pat  in  CNT_W  patterns to apply; sampled with start
- pat_o  out  N_IN  stimulus to both netlists (= lfsr[N_IN-1:0])
- gold_i  in  N_OUT  golden netlist outputs
- cand_i  in  N_OUT  candidate netlist outputs
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run; held until next start
- gold_sig  out  32  golden MISR signature
- cand_sig  out  32  candidate MISR signature
- fail_idx  out  CNT_W  index of first mismatching pattern (macro only, else 0)
- fail_vld  out  1  fail_idx valid (macro only, else 0)

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003); shift right, XOR mask when the shifted-out bit is 1.
- MISR per stream: next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h0400_0007 : 0) ^ zero-extended response.
- FSM: IDLE -> RUN on start with num_pat != 0; IDLE -> DONE on start with num_pat == 0; RUN -> DRAIN after num_pat patterns issued; DRAIN -> DONE after LAT cycles (skipped when LAT = 0); DONE -> IDLE unconditionally.
- On accepted start: LFSR <- SEED, both sigs <- 0, fail_vld <- 0, fail_idx <- 0, pattern counter <- 0.
- RUN: each cycle issues one pattern and advances the LFSR. A LAT-deep valid/index shift register tags each pattern. A response is compacted only when its tag emerges valid.
- DONE: done = 1; pass = (gold_sig == cand_sig) && !fail_vld.
- start while busy or in DONE: ignored.
- Reset values: state IDLE, LFSR = SEED, pat_o = SEED[N_IN-1:0], sigs 0, busy 0, done 0, pass 0, fail_idx 0, fail_vld 0.
- Reset mid-run: all state returns to reset values immediately; no done pulse.

## Timing
- Start sampled at edge T. Pattern 0 is on pat_o during cycle T+1, and pattern k during T+1+k.
- The response to pattern k is sampled at the end of cycle T+1+k+LAT.
- done is asserted in cycle T+2+num_pat+LAT. The pass and signature values are stable from that cycle.
- busy is high from T+1 through the last DRAIN cycle; busy and done are never high together.
- For num_pat = 0: done is asserted in cycle T+1, pass = 1, sigs = 0.

## Configuration
- EQV_SIG_DIRECT_CMP_EN defined: each valid response pair is compared bitwise. On the first mismatch, fail_vld <- 1 and fail_idx <- the pattern index, and later mismatches do not overwrite them. pass also requires fail_vld == 0, which catches MISR aliasing.
- Undefined: no comparator or index pipeline is built; fail_idx and fail_vld are tied to 0; pass relies on signatures only.

## Test plan
- Identical netlists (cand = gold = pat_o[7:0] ^ 8'h5A), num_pat = 100, LAT = 1 -> done at T+103, pass = 1, gold_sig == cand_sig != 0.
- Candidate bit 3 inverted only on pattern 37, macro on -> pass = 0, fail_vld = 1, fail_idx = 37; macro off -> pass = 0 via signature mismatch.
- num_pat = 0 -> done one cycle after start, pass = 1, busy never asserted, sigs = 0.
- rst_n low for one cycle at pattern 20 of a 50-pattern run -> no done pulse, all outputs at reset values. A new start then completes normally.
- start pulsed every cycle during a 10-pattern run -> only one run and a single done pulse; num_pat changes mid-run are ignored.
- LAT = 0 and LAT = 4 with the same seed and identical netlists -> identical final gold_sig for both; done latencies are T+2+num_pat and T+6+num_pat.
